// File: rtl/rd_beat_packer.sv
// rd_beat_packer: packs BEATS consecutive 32-bit read words into wide packets and
// buffers them in a DEPTH-entry valid/ready FIFO, dropping packets that find it full.
module rd_beat_packer #(
    parameter int BEATS = 2,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rd_valid_i,
    input  logic [31:0]                  rd_data_i,
    input  logic                         flush_i,
    input  logic                         ovf_clr_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [32*BEATS-1:0]          out_data_o,
    output logic [$clog2(BEATS):0]       out_cnt_o,
    output logic                         overflow_o,
    output logic [7:0]                   drop_cnt_o
);
    localparam int IW = $clog2(BEATS);
    localparam int CW = IW + 1;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = 32 * BEATS;

    typedef enum logic {ST_IDLE, ST_FILL} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [PW-1:0]   asm_q, asm_d, pkt;
    logic [CW-1:0]   pkt_cnt;
    logic [PW-1:0]   data_mem_q [DEPTH];
    logic [CW-1:0]   cnt_mem_q [DEPTH];
    logic [AW:0]     wptr_q, rptr_q;
    logic            overflow_q;
    logic [7:0]      drop_cnt_q;
    logic            last, push, full, empty, pop, accept, drop;

    // The incoming word lands in its slot before any push, so a flush on the same
    // cycle as a word carries that word in the packet.
    always_comb begin
        pkt = asm_q;
        if (rd_valid_i) pkt[32*int'(idx_q) +: 32] = rd_data_i;
        last    = rd_valid_i && (idx_q == IW'(BEATS - 1));
        push    = last || (flush_i && (state_q == ST_FILL || rd_valid_i));
        pkt_cnt = CW'(idx_q) + CW'(rd_valid_i);
        idx_d   = push ? '0 : idx_q + IW'(rd_valid_i);
        state_d = (idx_d == '0) ? ST_IDLE : ST_FILL;
        asm_d   = push ? '0 : pkt;
    end

    assign empty  = wptr_q == rptr_q;
    assign full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop    = ~empty & out_ready_i;
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            asm_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_q[i] <= '0;
                cnt_mem_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            asm_q   <= asm_d;
            if (accept) begin
                data_mem_q[wptr_q[AW-1:0]] <= pkt;
                cnt_mem_q[wptr_q[AW-1:0]]  <= pkt_cnt;
                wptr_q                     <= wptr_q + 1'b1;
            end
            if (pop) rptr_q <= rptr_q + 1'b1;
            // A drop on the clearing cycle wins, so the new count restarts at one.
            if (drop) begin
                overflow_q <= 1'b1;
                drop_cnt_q <= ovf_clr_i ? 8'd1 : (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;
            end else if (ovf_clr_i) begin
                overflow_q <= 1'b0;
                drop_cnt_q <= '0;
            end
        end
    end

    assign out_valid_o = ~empty;
    assign out_data_o  = empty ? '0 : data_mem_q[rptr_q[AW-1:0]];
    assign out_cnt_o   = empty ? '0 : cnt_mem_q[rptr_q[AW-1:0]];
    assign overflow_o  = overflow_q;
    assign drop_cnt_o  = drop_cnt_q;
endmodule

// File: tb/tb_rd_beat_packer.sv
// tb_rd_beat_packer: directed self-checking bench for rd_beat_packer (BEATS=2, DEPTH=4).
module tb_rd_beat_packer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_valid_i = 1'b0;
    logic [31:0] rd_data_i = '0;
    logic        flush_i = 1'b0;
    logic        ovf_clr_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [63:0] out_data_o;
    logic [1:0]  out_cnt_o;
    logic        overflow_o;
    logic [7:0]  drop_cnt_o;
    int          n_assert = 0;
    int          n_fail = 0;

    rd_beat_packer #(.BEATS(2), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .rd_valid_i(rd_valid_i), .rd_data_i(rd_data_i),
        .flush_i(flush_i), .ovf_clr_i(ovf_clr_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_cnt_o(out_cnt_o),
        .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_pkt(input logic [31:0] a, input logic [31:0] b);
        rd_valid_i = 1'b1;
        rd_data_i  = a;
        tick();
        rd_data_i  = b;
        tick();
        rd_valid_i = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 64'(out_valid_o), 64'd0);
        chk({tag, "_data"}, out_data_o, 64'd0);
        chk({tag, "_cnt"}, 64'(out_cnt_o), 64'd0);
    endtask

    initial begin
        logic [31:0] lo;
        tick();
        tick();
        chk_idle("reset");
        chk("reset_ovf", 64'(overflow_o), 64'd0);
        chk("reset_drop", 64'(drop_cnt_o), 64'd0);
        reset = 1'b0;
        tick();

        // Two back-to-back words form a full packet, popped next cycle.
        send_pkt(32'h11, 32'h22);
        chk("t1_valid", 64'(out_valid_o), 64'd1);
        chk("t1_data", out_data_o, 64'h00000022_00000011);
        chk("t1_cnt", 64'(out_cnt_o), 64'd2);
        tick();
        chk_idle("t1_pop");

        // Partial packet via flush; flush while idle emits nothing.
        rd_valid_i = 1'b1; rd_data_i = 32'hAB;
        tick();
        rd_valid_i = 1'b0; flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("t2_valid", 64'(out_valid_o), 64'd1);
        chk("t2_data", out_data_o, 64'h00000000_000000AB);
        chk("t2_cnt", 64'(out_cnt_o), 64'd1);
        tick();
        chk_idle("t2_pop");
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk_idle("t2_idle_flush");
        tick();
        chk_idle("t2_idle_flush2");

        // Flush with the completing word yields one full packet only.
        rd_valid_i = 1'b1; rd_data_i = 32'h1;
        tick();
        rd_data_i = 32'h2; flush_i = 1'b1;
        tick();
        rd_valid_i = 1'b0; flush_i = 1'b0;
        chk("t3_valid", 64'(out_valid_o), 64'd1);
        chk("t3_data", out_data_o, 64'h00000002_00000001);
        chk("t3_cnt", 64'(out_cnt_o), 64'd2);
        tick();
        chk_idle("t3_no_extra");

        // Five packets into a stalled 4-deep FIFO: the fifth is dropped.
        out_ready_i = 1'b0;
        for (int p = 0; p < 5; p++) send_pkt(32'h100 + 32'(2*p), 32'h101 + 32'(2*p));
        chk("t4_ovf", 64'(overflow_o), 64'd1);
        chk("t4_drop", 64'(drop_cnt_o), 64'd1);
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lo = 32'h100 + 32'(2*i);
            chk("t4_drain_valid", 64'(out_valid_o), 64'd1);
            chk("t4_drain_data", out_data_o, {lo + 32'd1, lo});
            chk("t4_drain_cnt", 64'(out_cnt_o), 64'd2);
            tick();
        end
        chk_idle("t4_empty");

        // Clear, refill, then push coincident with pop into a full FIFO.
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        chk("t5_clr_ovf", 64'(overflow_o), 64'd0);
        chk("t5_clr_drop", 64'(drop_cnt_o), 64'd0);
        out_ready_i = 1'b0;
        for (int p = 0; p < 4; p++) send_pkt(32'hA00 + 32'(2*p), 32'hA01 + 32'(2*p));
        rd_valid_i = 1'b1; rd_data_i = 32'hA08;
        tick();
        rd_data_i = 32'hA09; out_ready_i = 1'b1;
        tick();
        rd_valid_i = 1'b0; out_ready_i = 1'b0;
        chk("t5_coinc_drop", 64'(drop_cnt_o), 64'd0);
        chk("t5_coinc_ovf", 64'(overflow_o), 64'd0);
        chk("t5_coinc_head", out_data_o, 64'h00000A03_00000A02);
        send_pkt(32'hB0, 32'hB1);
        chk("t5_drop1", 64'(drop_cnt_o), 64'd1);
        rd_valid_i = 1'b1; rd_data_i = 32'hC0;
        tick();
        rd_data_i = 32'hC1; ovf_clr_i = 1'b1;
        tick();
        rd_valid_i = 1'b0; ovf_clr_i = 1'b0;
        chk("t5_clr_drop_wins_ovf", 64'(overflow_o), 64'd1);
        chk("t5_clr_drop_wins_cnt", 64'(drop_cnt_o), 64'd1);
        out_ready_i = 1'b1;
        for (int i = 1; i < 5; i++) begin
            lo = 32'hA00 + 32'(2*i);
            chk("t5_drain_data", out_data_o, {lo + 32'd1, lo});
            tick();
        end
        chk_idle("t5_empty");
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        chk("t5_final_clr", 64'(drop_cnt_o), 64'd0);

        // Reset mid-packet with two queued packets.
        out_ready_i = 1'b0;
        send_pkt(32'hD0, 32'hD1);
        send_pkt(32'hD2, 32'hD3);
        rd_valid_i = 1'b1; rd_data_i = 32'hEE;
        tick();
        rd_valid_i = 1'b0;
        chk("t6_pre_valid", 64'(out_valid_o), 64'd1);
        reset = 1'b1;
        #1;
        chk_idle("t6_async");
        tick();
        reset = 1'b0;
        send_pkt(32'h77, 32'h88);
        chk("t6_valid", 64'(out_valid_o), 64'd1);
        chk("t6_data", out_data_o, 64'h00000088_00000077);
        chk("t6_cnt", 64'(out_cnt_o), 64'd2);
        out_ready_i = 1'b1;
        tick();
        chk_idle("t6_empty");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
